vc_fill_ctrl: RTL and testbench

- Victim-cache fill/replacement controller in the dcache, directly upstream of the victim-cache tag RAM and data RAM.
- Accepts lines evicted from the L1 dcache and selects a victim-cache way: lowest invalid way first, otherwise a round-robin pointer.
- If the displaced entry is valid and dirty, it is read from the data RAM and written back to memory first.
- Then it drives the tag-RAM write port (wr_en/wr_way/wr_tag) and the data-RAM write port for the new line.

---
 rtl/hpu_pkg.sv | 18 +
 rtl/vc_fill_ctrl_if.sv | 30 +++
 rtl/vc_fill_ctrl_victim_sel.sv | 25 ++
 rtl/vc_fill_ctrl.sv | 168 ++++++++++++++++
 tb/tb_vc_fill_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/hpu_pkg.sv
// rtl/hpu_pkg.sv - shared victim-cache widths and the fill controller state encoding
package hpu_pkg;

    localparam int AWT_DEF         = 32;
    localparam int WORD_SEL_DEF    = 4;
    localparam int VC_WAYS_EXP_DEF = 2;
    localparam int TAG_WT_VC_DEF   = AWT_DEF - WORD_SEL_DEF - 2;
    localparam int LINE_WT_DEF     = 32 * (2 ** WORD_SEL_DEF);

    typedef enum logic [2:0] {
        VC_IDLE,
        VC_RD,
        VC_RDW,
        VC_WB,
        VC_FILL
    } vc_fill_st_e;

endpackage

// File: rtl/vc_fill_ctrl_if.sv
// rtl/vc_fill_ctrl_if.sv - eviction request and memory writeback channels of the fill controller
interface vc_fill_ctrl_if
    import hpu_pkg::*;
#(
    parameter int AWT       = AWT_DEF,
    parameter int TAG_WT_VC = TAG_WT_VC_DEF,
    parameter int LINE_WT   = LINE_WT_DEF
);
    logic                 evict_valid_i;
    logic                 evict_ready_o;
    logic [TAG_WT_VC-1:0] evict_tag_i;
    logic                 evict_dirty_i;
    logic [LINE_WT-1:0]   evict_data_i;

    logic                 wb_valid_o;
    logic                 wb_ready_i;
    logic [AWT-1:0]       wb_addr_o;
    logic [LINE_WT-1:0]   wb_data_o;

    modport slave (
        input  evict_valid_i, evict_tag_i, evict_dirty_i, evict_data_i, wb_ready_i,
        output evict_ready_o, wb_valid_o, wb_addr_o, wb_data_o
    );

    modport master (
        output evict_valid_i, evict_tag_i, evict_dirty_i, evict_data_i, wb_ready_i,
        input  evict_ready_o, wb_valid_o, wb_addr_o, wb_data_o
    );

endinterface

// File: rtl/vc_fill_ctrl_victim_sel.sv
// rtl/vc_fill_ctrl_victim_sel.sv - victim way choice: lowest invalid way, else the round-robin pointer
module vc_victim_sel
    import hpu_pkg::*;
#(
    parameter int VC_WAYS_EXP = VC_WAYS_EXP_DEF,
    localparam int VC_WAYS    = 2 ** VC_WAYS_EXP
) (
    input  logic [VC_WAYS-1:0]     valid_i,
    input  logic [VC_WAYS_EXP-1:0] rr_ptr_i,
    output logic [VC_WAYS_EXP-1:0] way_o,
    output logic                   all_valid_o
);

    always_comb begin
        way_o       = rr_ptr_i;
        all_valid_o = &valid_i;
        // Walk downwards so the lowest invalid index is the last one to win.
        for (int i = VC_WAYS - 1; i >= 0; i--) begin
            if (!valid_i[i]) begin
                way_o = VC_WAYS_EXP'(i);
            end
        end
    end

endmodule

// File: rtl/vc_fill_ctrl.sv
// rtl/vc_fill_ctrl.sv - victim-cache fill/replacement controller with dirty-victim writeback
module vc_fill_ctrl
    import hpu_pkg::*;
#(
    parameter int AWT         = AWT_DEF,
    parameter int WORD_SEL    = WORD_SEL_DEF,
    parameter int VC_WAYS_EXP = VC_WAYS_EXP_DEF
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    vc_fill_ctrl_if.slave                       ev,
    input  logic [(2**VC_WAYS_EXP)-1:0]         vc_valid_i,
    input  logic                                dirty_set_i,
    input  logic [VC_WAYS_EXP-1:0]              dirty_set_way_i,
    input  logic                                clear_all_i,
    input  logic                                clear_line_i,
    input  logic [VC_WAYS_EXP-1:0]              clear_way_i,
    output logic                                tag_wr_en_o,
    output logic [VC_WAYS_EXP-1:0]              tag_wr_way_o,
    output logic [AWT-WORD_SEL-3:0]             tag_wr_tag_o,
    output logic                                data_wr_en_o,
    output logic [VC_WAYS_EXP-1:0]              data_wr_way_o,
    output logic [32*(2**WORD_SEL)-1:0]         data_wr_line_o,
    output logic                                data_rd_en_o,
    output logic [VC_WAYS_EXP-1:0]              data_rd_way_o,
    input  logic [32*(2**WORD_SEL)-1:0]         data_rd_line_i,
    output logic                                busy_o
);

    localparam int TAG_WT_VC = AWT - WORD_SEL - 2;
    localparam int VC_WAYS   = 2 ** VC_WAYS_EXP;
    localparam int LINE_WT   = 32 * (2 ** WORD_SEL);

    vc_fill_st_e                          state_q, state_d;
    logic [VC_WAYS_EXP-1:0]               rr_ptr_q, rr_ptr_d;
    logic [VC_WAYS-1:0]                   dirty_q, dirty_d;
    logic [VC_WAYS_EXP-1:0]               way_q, way_d;
    logic                                 vdirty_q, vdirty_d;
    logic                                 vfull_q, vfull_d;
    logic [TAG_WT_VC-1:0]                 vtag_q, vtag_d;
    logic [VC_WAYS-1:0][TAG_WT_VC-1:0]    shadow_q, shadow_d;
    logic [AWT-1:0]                       wb_addr_q, wb_addr_d;
    logic [LINE_WT-1:0]                   wb_data_q, wb_data_d;

    logic [VC_WAYS_EXP-1:0]               sel_way;
    logic                                 sel_all;

    vc_victim_sel #(
        .VC_WAYS_EXP (VC_WAYS_EXP)
    ) u_victim_sel (
        .valid_i     (vc_valid_i),
        .rr_ptr_i    (rr_ptr_q),
        .way_o       (sel_way),
        .all_valid_o (sel_all)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= VC_IDLE;
            rr_ptr_q  <= '0;
            dirty_q   <= '0;
            way_q     <= '0;
            vdirty_q  <= 1'b0;
            vfull_q   <= 1'b0;
            vtag_q    <= '0;
            shadow_q  <= '0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            dirty_q   <= dirty_d;
            way_q     <= way_d;
            vdirty_q  <= vdirty_d;
            vfull_q   <= vfull_d;
            vtag_q    <= vtag_d;
            shadow_q  <= shadow_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        way_d          = way_q;
        vdirty_d       = vdirty_q;
        vfull_d        = vfull_q;
        vtag_d         = vtag_q;
        shadow_d       = shadow_q;
        wb_addr_d      = wb_addr_q;
        wb_data_d      = wb_data_q;
        ev.evict_ready_o = 1'b0;
        ev.wb_valid_o    = 1'b0;
        tag_wr_en_o    = 1'b0;
        tag_wr_way_o   = '0;
        tag_wr_tag_o   = '0;
        data_wr_en_o   = 1'b0;
        data_wr_way_o  = '0;
        data_wr_line_o = '0;
        data_rd_en_o   = 1'b0;
        data_rd_way_o  = '0;

        case (state_q)
            VC_IDLE: begin
                if (ev.evict_valid_i) begin
                    way_d    = sel_way;
                    vdirty_d = ev.evict_dirty_i;
                    vfull_d  = sel_all;
                    vtag_d   = ev.evict_tag_i;
                    // Only a full cache can pick a valid way, so sel_all stands in for the valid bit.
                    state_d  = (sel_all && dirty_q[sel_way]) ? VC_RD : VC_FILL;
                end
            end
            VC_RD: begin
                data_rd_en_o  = 1'b1;
                data_rd_way_o = way_q;
                state_d       = VC_RDW;
            end
            VC_RDW: begin
                wb_data_d = data_rd_line_i;
                wb_addr_d = {shadow_q[way_q], {(WORD_SEL + 2){1'b0}}};
                state_d   = VC_WB;
            end
            VC_WB: begin
                ev.wb_valid_o = 1'b1;
                if (ev.wb_ready_i) begin
                    state_d = VC_FILL;
                end
            end
            VC_FILL: begin
                tag_wr_en_o      = 1'b1;
                tag_wr_way_o     = way_q;
                tag_wr_tag_o     = ev.evict_tag_i;
                data_wr_en_o     = 1'b1;
                data_wr_way_o    = way_q;
                data_wr_line_o   = ev.evict_data_i;
                ev.evict_ready_o = 1'b1;
                shadow_d[way_q]  = vtag_q;
                if (vfull_q) begin
                    rr_ptr_d = rr_ptr_q + VC_WAYS_EXP'(1);
                end
                state_d = VC_IDLE;
            end
            default: state_d = VC_IDLE;
        endcase

        // Lowest priority first so later assignments override earlier ones.
        dirty_d = dirty_q;
        if (dirty_set_i) begin
            dirty_d[dirty_set_way_i] = 1'b1;
        end
        if (state_q == VC_FILL) begin
            dirty_d[way_q] = vdirty_q;
        end
        if (clear_line_i) begin
            dirty_d[clear_way_i] = 1'b0;
        end
        if (clear_all_i) begin
            dirty_d = '0;
        end
    end

    assign ev.wb_addr_o = wb_addr_q;
    assign ev.wb_data_o = wb_data_q;
    assign busy_o       = (state_q != VC_IDLE);

endmodule

// File: tb/tb_vc_fill_ctrl.sv
// tb/tb_vc_fill_ctrl.sv - directed self-checking bench for vc_fill_ctrl
module tb_vc_fill_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   vc_valid = 4'b0000;
    logic         dirty_set = 1'b0;
    logic [1:0]   dirty_set_way = 2'd0;
    logic         clear_all = 1'b0;
    logic         clear_line = 1'b0;
    logic [1:0]   clear_way = 2'd0;
    logic         tag_wr_en, data_wr_en, data_rd_en, busy;
    logic [1:0]   tag_wr_way, data_wr_way, data_rd_way;
    logic [25:0]  tag_wr_tag;
    logic [511:0] data_wr_line;
    logic [511:0] rd_line = '0;
    logic [511:0] ram [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vc_fill_ctrl_if #(.AWT(32), .TAG_WT_VC(26), .LINE_WT(512)) evif ();

    vc_fill_ctrl #(.AWT(32), .WORD_SEL(4), .VC_WAYS_EXP(2)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .ev              (evif.slave),
        .vc_valid_i      (vc_valid),
        .dirty_set_i     (dirty_set),
        .dirty_set_way_i (dirty_set_way),
        .clear_all_i     (clear_all),
        .clear_line_i    (clear_line),
        .clear_way_i     (clear_way),
        .tag_wr_en_o     (tag_wr_en),
        .tag_wr_way_o    (tag_wr_way),
        .tag_wr_tag_o    (tag_wr_tag),
        .data_wr_en_o    (data_wr_en),
        .data_wr_way_o   (data_wr_way),
        .data_wr_line_o  (data_wr_line),
        .data_rd_en_o    (data_rd_en),
        .data_rd_way_o   (data_rd_way),
        .data_rd_line_i  (rd_line),
        .busy_o          (busy)
    );

    // Tag-RAM valid bits and data RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (tag_wr_en) vc_valid[tag_wr_way] <= 1'b1;
        if (data_wr_en) ram[data_wr_way] <= data_wr_line;
        if (data_rd_en) rd_line <= ram[data_rd_way];
    end

    function automatic logic [511:0] line_of(input logic [25:0] t);
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = {2'b01, 4'(i), t};
        return l;
    endfunction

    task automatic pulse_dirty_set(input logic [1:0] way);
        @(negedge clk);
        dirty_set = 1'b1; dirty_set_way = way;
        @(negedge clk);
        dirty_set = 1'b0;
    endtask

    task automatic do_evict(input logic [25:0] tag, input logic dirty, input logic [1:0] exp_way,
                            input logic exp_wb, input logic [31:0] exp_addr, input logic [25:0] src_tag,
                            input int hold, input int exp_cycles, input logic clr_all_wb, input string name);
        int cycles = 0;
        int wait_cnt = 0;
        logic done = 1'b0;
        logic wb_seen = 1'b0;
        logic [511:0] exp_data = line_of(src_tag);
        @(negedge clk);
        evif.evict_tag_i = tag; evif.evict_dirty_i = dirty;
        evif.evict_data_i = line_of(tag); evif.evict_valid_i = 1'b1;
        while (!done && cycles < 50) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            clear_all = 1'b0;
            if (data_rd_en) begin
                checks++;
                if (data_rd_way !== exp_way) begin
                    errors++; $display("FAIL %s rd_way: got %0d want %0d", name, data_rd_way, exp_way);
                end
            end
            if (evif.wb_valid_o) begin
                if (!wb_seen && clr_all_wb) clear_all = 1'b1;
                wb_seen = 1'b1;
                checks++;
                if (evif.wb_addr_o !== exp_addr || evif.wb_data_o !== exp_data) begin
                    errors++;
                    $display("FAIL %s wb_addr/data cycle %0d: got %h want %h (data ok=%0d)",
                             name, cycles, evif.wb_addr_o, exp_addr, evif.wb_data_o === exp_data);
                end
                evif.wb_ready_i = (wait_cnt >= hold);
                wait_cnt++;
            end else begin
                evif.wb_ready_i = 1'b0;
            end
            if (evif.evict_ready_o) begin
                done = 1'b1;
                checks++;
                if (cycles != exp_cycles) begin
                    errors++; $display("FAIL %s latency: got %0d want %0d", name, cycles, exp_cycles);
                end
                checks++;
                if (tag_wr_en !== 1'b1 || data_wr_en !== 1'b1 || busy !== 1'b1) begin
                    errors++; $display("FAIL %s fill strobes: got %b%b%b want 111", name, tag_wr_en, data_wr_en, busy);
                end
                checks++;
                if (tag_wr_way !== exp_way || data_wr_way !== exp_way) begin
                    errors++; $display("FAIL %s fill way: got %0d/%0d want %0d", name, tag_wr_way, data_wr_way, exp_way);
                end
                checks++;
                if (tag_wr_tag !== tag || data_wr_line !== line_of(tag)) begin
                    errors++; $display("FAIL %s fill tag: got %h want %h", name, tag_wr_tag, tag);
                end
                evif.evict_valid_i = 1'b0;
            end
        end
        checks++;
        if (!done) begin
            errors++; $display("FAIL %s timeout: got no ready want ready within 50 cycles", name);
        end
        checks++;
        if (wb_seen !== exp_wb) begin
            errors++; $display("FAIL %s writeback: got %0d want %0d", name, wb_seen, exp_wb);
        end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({evif.evict_ready_o, tag_wr_en, data_wr_en, data_rd_en, evif.wb_valid_o, busy} !== 6'b0) begin
            errors++; $display("FAIL reset strobes: got %b want 000000",
                {evif.evict_ready_o, tag_wr_en, data_wr_en, data_rd_en, evif.wb_valid_o, busy});
        end
        checks++;
        if (tag_wr_way !== 0 || tag_wr_tag !== 0 || data_wr_way !== 0 || data_wr_line !== 0 ||
            data_rd_way !== 0 || evif.wb_addr_o !== 0 || evif.wb_data_o !== 0) begin
            errors++; $display("FAIL reset data: got wb_addr %h tag %h want 0", evif.wb_addr_o, tag_wr_tag);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fill_empty;
        for (int i = 0; i < 4; i++)
            do_evict(26'h10 + 26'(i), 1'b0, 2'(i), 1'b0, 32'h0, 26'h0, 0, 1, 1'b0, "fill_empty");
    endtask

    task automatic test_round_robin;
        for (int i = 0; i < 4; i++)
            do_evict(26'h20 + 26'(i), 1'b0, 2'(i), 1'b0, 32'h0, 26'h0, 0, 1, 1'b0, "round_robin");
    endtask

    task automatic test_dirty_wb;
        do_evict(26'h10, 1'b1, 2'd0, 1'b0, 32'h0, 26'h0, 0, 1, 1'b0, "rr_wrap");
        for (int i = 1; i < 4; i++)
            do_evict(26'h13 + 26'(i), 1'b0, 2'(i), 1'b0, 32'h0, 26'h0, 0, 1, 1'b0, "dirty_setup");
        do_evict(26'h30, 1'b0, 2'd0, 1'b1, 32'h0000_0400, 26'h10, 3, 7, 1'b0, "dirty_wb_hold");
    endtask

    task automatic test_clear_priority;
        @(negedge clk);
        dirty_set = 1'b1; dirty_set_way = 2'd0; clear_line = 1'b1; clear_way = 2'd0;
        @(negedge clk);
        dirty_set = 1'b0; clear_line = 1'b0;
        for (int i = 1; i < 4; i++)
            do_evict(26'h30 + 26'(i), 1'b0, 2'(i), 1'b0, 32'h0, 26'h0, 0, 1, 1'b0, "clr_setup");
        do_evict(26'h34, 1'b0, 2'd0, 1'b0, 32'h0, 26'h0, 0, 1, 1'b0, "clear_line_wins");
        pulse_dirty_set(2'd1);
        do_evict(26'h35, 1'b0, 2'd1, 1'b1, 32'h0000_0C40, 26'h31, 0, 4, 1'b0, "dirty_set_wb");
    endtask

    task automatic test_clear_all_wb;
        pulse_dirty_set(2'd2);
        pulse_dirty_set(2'd3);
        do_evict(26'h40, 1'b1, 2'd2, 1'b1, 32'h0000_0C80, 26'h32, 2, 6, 1'b1, "clear_all_in_wb");
        do_evict(26'h41, 1'b0, 2'd3, 1'b0, 32'h0, 26'h0, 0, 1, 1'b0, "cleared_way3");
        do_evict(26'h42, 1'b0, 2'd0, 1'b0, 32'h0, 26'h0, 0, 1, 1'b0, "post_clr_w0");
        do_evict(26'h43, 1'b0, 2'd1, 1'b0, 32'h0, 26'h0, 0, 1, 1'b0, "post_clr_w1");
        do_evict(26'h44, 1'b0, 2'd2, 1'b1, 32'h0000_1000, 26'h40, 0, 4, 1'b0, "new_dirty_kept");
    endtask

    task automatic test_reset_in_wb;
        int cycles = 0;
        pulse_dirty_set(2'd3);
        @(negedge clk);
        evif.evict_tag_i = 26'h50; evif.evict_dirty_i = 1'b0;
        evif.evict_data_i = line_of(26'h50); evif.evict_valid_i = 1'b1;
        while (evif.wb_valid_o !== 1'b1 && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        checks++;
        if (evif.wb_valid_o !== 1'b1) begin
            errors++; $display("FAIL reset_in_wb reach_wb: got %b want 1", evif.wb_valid_o);
        end
        rst = 1'b1;
        evif.evict_valid_i = 1'b0;
        #1;
        checks++;
        if ({evif.evict_ready_o, tag_wr_en, data_wr_en, data_rd_en, evif.wb_valid_o, busy} !== 6'b0) begin
            errors++; $display("FAIL reset_in_wb strobes: got %b want 000000",
                {evif.evict_ready_o, tag_wr_en, data_wr_en, data_rd_en, evif.wb_valid_o, busy});
        end
        checks++;
        if (evif.wb_addr_o !== 0 || evif.wb_data_o !== 0 || tag_wr_tag !== 0) begin
            errors++; $display("FAIL reset_in_wb data: got wb_addr %h want 0", evif.wb_addr_o);
        end
        @(negedge clk);
        rst = 1'b0;
        do_evict(26'h51, 1'b0, 2'd0, 1'b0, 32'h0, 26'h0, 0, 1, 1'b0, "after_reset");
    endtask

    initial begin
        evif.evict_valid_i = 1'b0;
        evif.evict_tag_i   = '0;
        evif.evict_dirty_i = 1'b0;
        evif.evict_data_i  = '0;
        evif.wb_ready_i    = 1'b0;
        test_reset();
        test_fill_empty();
        test_round_robin();
        test_dirty_wb();
        test_clear_priority();
        test_clear_all_wb();
        test_reset_in_wb();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
